// File: rtl/ps2_tone_synth.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tone_synth
// Description : Polyphonic square-wave tone generator driven by raw PS/2
//               scan-code bytes. Decodes make/break/E0 sequences, tracks
//               eight mapped keys, assigns held keys to tone voices, mixes
//               the voices and paces the mix into an audio write port.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_tone_synth #(
    parameter int NUM_VOICES = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int SAMPLE_HZ  = 48000,
    parameter int SAMPLE_W   = 32,
    parameter int AMPLITUDE  = 25000000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [7:0]                 received_data,
    input  logic                       received_data_en,
    input  logic                       audio_out_allowed,
    output logic signed [SAMPLE_W-1:0] left_channel_audio_out,
    output logic signed [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                       write_audio_out,
    output logic [7:0]                 key_held,
    output logic [NUM_VOICES-1:0]      voice_active,
    output logic                       voice_overflow,
    output logic                       sample_dropped
);

    localparam int c_SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int c_DIV_W      = $clog2(c_SAMPLE_DIV + 1);
    // Widest half-period belongs to the lowest note (262 Hz).
    localparam int c_CNT_W      = $clog2(CLK_HZ / (2 * 262) + 1);
    localparam logic signed [SAMPLE_W-1:0] c_AMP = SAMPLE_W'(AMPLITUDE);

    localparam longint c_MIX_MAX = longint'(NUM_VOICES) * longint'(AMPLITUDE);
    localparam longint c_MIX_LIM = longint'(1) << (SAMPLE_W - 1);

    // Reject configurations whose worst-case mix cannot fit the sample width.
    generate
        if (c_MIX_MAX >= c_MIX_LIM || NUM_VOICES < 1 || NUM_VOICES > 8) begin : g_param_err
            $error("ps2_tone_synth: NUM_VOICES*AMPLITUDE must fit in SAMPLE_W-1 bits, NUM_VOICES in 1..8");
        end
    endgenerate

    // Half-period in clock cycles for each key index.
    function automatic logic [c_CNT_W-1:0] f_half(input logic [2:0] k);
        case (k)
            3'd0:    f_half = c_CNT_W'(CLK_HZ / (2 * 440));
            3'd1:    f_half = c_CNT_W'(CLK_HZ / (2 * 490));
            3'd2:    f_half = c_CNT_W'(CLK_HZ / (2 * 624));
            3'd3:    f_half = c_CNT_W'(CLK_HZ / (2 * 580));
            3'd4:    f_half = c_CNT_W'(CLK_HZ / (2 * 669));
            3'd5:    f_half = c_CNT_W'(CLK_HZ / (2 * 262));
            3'd6:    f_half = c_CNT_W'(CLK_HZ / (2 * 294));
            default: f_half = c_CNT_W'(CLK_HZ / (2 * 330));
        endcase
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_make;
    logic                    w_break;
    logic                    w_ext;
    logic                    w_key_vld;
    logic [2:0]              w_key_idx;
    logic                    w_do_make;
    logic                    w_do_break;

    logic [7:0]              r_key_held;
    logic                    r_overflow;
    logic [NUM_VOICES-1:0]   r_v_active;
    logic [2:0]              r_v_key   [NUM_VOICES];
    logic [c_CNT_W-1:0]      r_v_cnt   [NUM_VOICES];
    logic [NUM_VOICES-1:0]   r_v_phase;
    logic [NUM_VOICES-1:0]   w_free_oh;
    logic                    w_free_vld;
    logic [NUM_VOICES-1:0]   w_v_hit;
    logic [NUM_VOICES-1:0]   w_v_wrap;

    logic signed [SAMPLE_W-1:0] w_mix;
    logic signed [SAMPLE_W-1:0] r_mix;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic [c_DIV_W-1:0]         r_div;
    logic                       w_tick;
    logic                       r_pending;
    logic                       r_dropped;
    logic                       w_write;

    // Parser state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Parser next-state and make/break event generation, advanced only on a strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_break     = 1'b0;
        if (received_data_en) begin
            if (received_data == 8'hE0) begin
                w_state_nxt = ST_EXT;
            end else if (received_data == 8'hF0) begin
                w_state_nxt = (r_state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
            end else begin
                w_state_nxt = ST_IDLE;
                if (r_state == ST_IDLE || r_state == ST_EXT) w_make  = 1'b1;
                else                                         w_break = 1'b1;
            end
        end
    end

    assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

    // Scan-code to key-index map; arrow keys accept an optional E0 prefix.
    always_comb begin
        w_key_vld = 1'b0;
        w_key_idx = 3'd0;
        case (received_data)
            8'h75: begin w_key_vld = 1'b1;   w_key_idx = 3'd0; end
            8'h72: begin w_key_vld = 1'b1;   w_key_idx = 3'd1; end
            8'h6B: begin w_key_vld = 1'b1;   w_key_idx = 3'd2; end
            8'h74: begin w_key_vld = 1'b1;   w_key_idx = 3'd3; end
            8'h29: begin w_key_vld = !w_ext; w_key_idx = 3'd4; end
            8'h1C: begin w_key_vld = !w_ext; w_key_idx = 3'd5; end
            8'h1B: begin w_key_vld = !w_ext; w_key_idx = 3'd6; end
            8'h23: begin w_key_vld = !w_ext; w_key_idx = 3'd7; end
            default: begin w_key_vld = 1'b0; w_key_idx = 3'd0; end
        endcase
    end

    // Typematic repeats of a held key and breaks of an unheld key are no-ops.
    assign w_do_make  = w_make  && w_key_vld && !r_key_held[w_key_idx];
    assign w_do_break = w_break && w_key_vld &&  r_key_held[w_key_idx];

    // Lowest clear bit of the active mask, one-hot; zero when all voices are busy.
    assign w_free_oh  = ~r_v_active & (r_v_active + NUM_VOICES'(1));
    assign w_free_vld = |w_free_oh;

    // Per-voice break match and half-period wrap detection.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_v_hit[v]  = r_v_active[v] && (r_v_key[v] == w_key_idx);
            w_v_wrap[v] = (r_v_cnt[v] == f_half(r_v_key[v]) - c_CNT_W'(1));
        end
    end

    // Held-key bitmap and sticky overflow flag.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_key_held <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_make)                r_key_held[w_key_idx] <= 1'b1;
            if (w_do_break)               r_key_held[w_key_idx] <= 1'b0;
            if (w_do_make && !w_free_vld) r_overflow <= 1'b1;
        end
    end

    // Voice allocation, release and square-wave half-period counters.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_v_active <= '0;
            r_v_phase  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_v_key[v] <= 3'd0;
                r_v_cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_do_make && w_free_oh[v]) begin
                    r_v_active[v] <= 1'b1;
                    r_v_key[v]    <= w_key_idx;
                    r_v_cnt[v]    <= '0;
                    r_v_phase[v]  <= 1'b1;
                end else if (w_do_break && w_v_hit[v]) begin
                    r_v_active[v] <= 1'b0;
                end else if (r_v_active[v]) begin
                    if (w_v_wrap[v]) begin
                        r_v_cnt[v]   <= '0;
                        r_v_phase[v] <= ~r_v_phase[v];
                    end else begin
                        r_v_cnt[v]   <= r_v_cnt[v] + c_CNT_W'(1);
                    end
                end
            end
        end
    end

    // Signed sum of voice contributions; the width cannot overflow.
    always_comb begin
        w_mix = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_v_active[v]) w_mix = r_v_phase[v] ? (w_mix + c_AMP) : (w_mix - c_AMP);
        end
    end

    // Mixer output register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) r_mix <= '0;
        else       r_mix <= w_mix;
    end

    assign w_tick  = (r_div == c_DIV_W'(c_SAMPLE_DIV - 1));
    assign w_write = r_pending && audio_out_allowed;

    // Sample-rate divider, output latch and write handshake.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_div     <= '0;
            r_sample  <= '0;
            r_pending <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + c_DIV_W'(1);
            if (w_tick) begin
                r_sample  <= r_mix;
                r_pending <= 1'b1;
                // A write in the same cycle consumes the old sample, so nothing is lost.
                if (r_pending && !w_write) r_dropped <= 1'b1;
            end else if (w_write) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign left_channel_audio_out  = r_sample;
    assign right_channel_audio_out = r_sample;
    assign write_audio_out         = w_write;
    assign key_held                = r_key_held;
    assign voice_active            = r_v_active;
    assign voice_overflow          = r_overflow;
    assign sample_dropped          = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tone_synth.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_tone_synth
// Description : Self-checking bench for ps2_tone_synth with a cycle-level
//               behavioural model (absolute-time phase arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ps2_tone_synth;

    localparam int     NV  = 4;
    localparam longint AMP = 25000000;
    localparam int     DIV = 1041;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              en      = 1'b0;
    logic              allowed = 1'b1;
    logic [7:0]        data    = 8'd0;
    logic signed [31:0] left, right;
    logic              wr;
    logic [7:0]        held;
    logic [NV-1:0]     va;
    logic              ovf, drop;

    int n_checks = 0;
    int n_errors = 0;

    ps2_tone_synth dut (
        .CLOCK_50                (clk),
        .reset                   (rst),
        .received_data           (data),
        .received_data_en        (en),
        .audio_out_allowed       (allowed),
        .left_channel_audio_out  (left),
        .right_channel_audio_out (right),
        .write_audio_out         (wr),
        .key_held                (held),
        .voice_active            (va),
        .voice_overflow          (ovf),
        .sample_dropped          (drop)
    );

    always #10 clk = ~clk;

    int hp_tab [8] = '{56818, 51020, 40064, 43103, 37369, 95419, 85034, 75757};

    // Reference model state
    bit            m_valid = 1'b0;
    logic [7:0]    m_held;
    logic [NV-1:0] m_act;
    int            m_key   [NV];
    longint        m_start [NV];
    logic          m_ovf, m_drop, m_pend;
    longint        m_sample, m_mix, m_cyc;
    bit            p_ext, p_brk;

    // Monitors
    bit mon_single = 1'b0;
    bit mon_poly   = 1'b0;
    int n_pos = 0, n_neg = 0, poly_bad = 0, wr_count = 0;

    function automatic int key_of(input logic [7:0] code, input bit ext);
        case (code)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            8'h29: return ext ? -1 : 4;
            8'h1C: return ext ? -1 : 5;
            8'h1B: return ext ? -1 : 6;
            8'h23: return ext ? -1 : 7;
            default: return -1;
        endcase
    endfunction

    // Model: advance one clock using absolute cycle arithmetic for tone phase.
    always @(posedge clk) begin : model
        longint s, el;
        int     k;
        bit     wnow, found;
        if (rst) begin
            m_valid = 1'b1;
            m_held = '0; m_act = '0; m_ovf = 0; m_drop = 0; m_pend = 0;
            m_sample = 0; m_mix = 0; m_cyc = 0; p_ext = 0; p_brk = 0;
        end else if (m_valid) begin
            wnow = m_pend && allowed;
            if ((m_cyc % DIV) == DIV - 1) begin
                m_sample = m_mix;
                if (m_pend && !wnow) m_drop = 1'b1;
                m_pend = 1'b1;
            end else if (wnow) begin
                m_pend = 1'b0;
            end
            s = 0;
            for (int v = 0; v < NV; v++) begin
                if (m_act[v]) begin
                    el = m_cyc - m_start[v];
                    s += (((el / hp_tab[m_key[v]]) % 2) == 0) ? AMP : -AMP;
                end
            end
            m_mix = s;
            if (en) begin
                if (data == 8'hE0) begin
                    p_ext = 1; p_brk = 0;
                end else if (data == 8'hF0) begin
                    p_ext = p_ext && !p_brk; p_brk = 1;
                end else begin
                    k = key_of(data, p_ext);
                    if (k >= 0 && !p_brk && !m_held[k]) begin
                        m_held[k] = 1'b1;
                        found = 0;
                        for (int v = 0; v < NV; v++) begin
                            if (!found && !m_act[v]) begin
                                found = 1; m_act[v] = 1'b1; m_key[v] = k; m_start[v] = m_cyc + 1;
                            end
                        end
                        if (!found) m_ovf = 1'b1;
                    end else if (k >= 0 && p_brk && m_held[k]) begin
                        m_held[k] = 1'b0;
                        for (int v = 0; v < NV; v++)
                            if (m_act[v] && m_key[v] == k) m_act[v] = 1'b0;
                    end
                    p_ext = 0; p_brk = 0;
                end
            end
            m_cyc = m_cyc + 1;
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if (held !== m_held || va !== m_act || ovf !== m_ovf || drop !== m_drop ||
                wr !== (m_pend && allowed)) begin
                n_errors++;
                $display("FAIL state cyc=%0d: held=%h exp %h va=%b exp %b ovf=%b exp %b drop=%b exp %b wr=%b exp %b",
                         m_cyc, held, m_held, va, m_act, ovf, m_ovf, drop, m_drop, wr, m_pend && allowed);
            end
            n_checks++;
            if (left !== m_sample[31:0] || right !== m_sample[31:0]) begin
                n_errors++;
                $display("FAIL sample cyc=%0d: left=%0d right=%0d exp %0d", m_cyc, left, right, m_sample);
            end
            if (wr) begin
                wr_count++;
                if (mon_single) begin
                    if (left == AMP) n_pos++;
                    else if (left == -AMP) n_neg++;
                end
                if (mon_poly && left != 2 * AMP && left != 0 && left != -2 * AMP) poly_bad++;
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data = b; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    logic [7:0] pool [12] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h1C, 8'h1B, 8'h23,
                              8'hE0, 8'hF0, 8'hF0, 8'h15};

    initial begin
        int w0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_flags", {held, va, ovf, drop, wr}, 0);
        chk("reset_sample", left, 0);

        // Sound a key, then reset in the middle of an E0 sequence.
        send(8'h75);
        cycles(1100);
        chk("pre_reset_sample", left, AMP);
        send(8'hE0);
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        chk("midreset_flags", {held, va, ovf, drop, wr}, 0);
        chk("midreset_sample", left, 0);
        send(8'h75);
        chk("midreset_held", held, 8'h01);
        send(8'hF0); send(8'h75);
        chk("midreset_break", held, 8'h00);

        // Single extended key across a full half-period.
        mon_single = 1'b1;
        send(8'hE0); send(8'h75);
        chk("single_held", held, 8'h01);
        chk("single_va", va, 4'b0001);
        cycles(58000);
        chk("single_pos_seen", n_pos > 0, 1);
        chk("single_neg_seen", n_neg > 0, 1);
        mon_single = 1'b0;
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("single_off_held", held, 8'h00);
        chk("single_off_va", va, 4'b0000);
        cycles(1100);
        chk("single_off_sample", left, 0);

        // Polyphony and voice reuse.
        mon_poly = 1'b1;
        send(8'h29); send(8'h1C);
        chk("poly_va", va, 4'b0011);
        chk("poly_held", held, 8'h30);
        cycles(3000);
        send(8'hF0); send(8'h29);
        chk("poly_free0", va, 4'b0010);
        send(8'h1B);
        chk("poly_reuse0", va, 4'b0011);
        chk("poly_held2", held, 8'h60);
        cycles(2000);
        mon_poly = 1'b0;
        chk("poly_levels", poly_bad, 0);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1B);

        // Overflow with five distinct keys, then typematic repeats.
        send(8'h29); send(8'h1C); send(8'h1B); send(8'h23);
        chk("ovf_full", va, 4'b1111);
        chk("ovf_none_yet", ovf, 0);
        send(8'h75);
        chk("ovf_held", held, 8'hF1);
        chk("ovf_flag", ovf, 1);
        send(8'h29); send(8'h29);
        chk("ovf_repeat_va", va, 4'b1111);
        chk("ovf_repeat_held", held, 8'hF1);
        send(8'hF0); send(8'h29); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h1B);
        send(8'hF0); send(8'h23); send(8'hF0); send(8'h75);
        chk("ovf_cleared", {held, va}, 0);

        // Handshake: hold off writes for 3000 cycles.
        allowed = 1'b0;
        w0 = wr_count;
        cycles(3000);
        chk("hs_no_write", wr_count - w0, 0);
        chk("hs_dropped", drop, 1);
        for (int i = 0; i < DIV && (m_cyc % DIV) != 500; i++) cycles(1);
        w0 = wr_count;
        allowed = 1'b1;
        cycles(2);
        chk("hs_one_pulse", wr_count - w0, 1);

        // Unmapped and stray bytes leave state untouched.
        send(8'h1C);
        send(8'h15); send(8'hF0); send(8'h15); send(8'hF0); send(8'h6B);
        chk("stray_held", held, 8'h20);
        chk("stray_va", va, 4'b0001);
        send(8'hF0); send(8'h1C);

        // Randomised byte stream, including strobes on consecutive cycles.
        for (int i = 0; i < 4000; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            data    = pool[$urandom_range(0, 11)];
            allowed = ($urandom_range(0, 9) != 0);
            @(posedge clk); #1;
        end
        en = 1'b0; allowed = 1'b1;
        cycles(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_tone_synth.md
# ps2_tone_synth

Polyphonic square-wave tone generator driven by raw PS/2 scan-code bytes. It decodes make, break and extended (E0) sequences, tracks eight mapped keys, and assigns held keys to up to NUM_VOICES tone voices. The voices are summed into a signed stereo sample, which is paced at SAMPLE_HZ into the Audio_Controller write port. It sits between PS2_Controller and Audio_Controller and replaces the single-tone key-to-frequency logic in the top module.

## Interface
- NUM_VOICES, 4: simultaneous tones, 1..8.
- CLK_HZ, 50000000: CLOCK_50 frequency.
- SAMPLE_HZ, 48000: output sample rate. SAMPLE_DIV = CLK_HZ/SAMPLE_HZ, truncated (1041).
- SAMPLE_W, 32: signed sample width.
- AMPLITUDE, 25000000: per-voice magnitude. NUM_VOICES*AMPLITUDE must be < 2^(SAMPLE_W-1), checked at elaboration.

Ports:
- CLOCK_50  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- received_data  in  8  PS/2 byte.
- received_data_en  in  1  one-cycle byte strobe, sampled on CLOCK_50 (never used as a clock).
- audio_out_allowed  in  1  Audio_Controller has FIFO space.
- left_channel_audio_out  out  SAMPLE_W  signed mixed sample.
- right_channel_audio_out  out  SAMPLE_W  identical to left.
- write_audio_out  out  1  one-cycle write pulse.
- key_held  out  8  held state per key index (for LEDR).
- voice_active  out  NUM_VOICES  per-voice busy flag.
- voice_overflow  out  1  sticky: a make was dropped because no voice was free.
- sample_dropped  out  1  sticky: a sample tick found the previous sample still pending.

## Operation
- Key map (index: code, frequency, half-period = CLK_HZ/(2f) truncated):
  - 0: 75 up, 440 Hz, 56818
  - 1: 72 down, 490 Hz, 51020
  - 2: 6B left, 624 Hz, 40064
  - 3: 74 right, 580 Hz, 43103
  - 4: 29 space, 669 Hz, 37369
  - 5: 1C A, 262 Hz, 95419
  - 6: 1B S, 294 Hz, 85034
  - 7: 23 D, 330 Hz, 75757
  - Codes 0–3 match with or without the E0 prefix.
- Parser FSM, states IDLE, EXT, BRK, EXT_BRK, advanced only on a strobe:
  - In any state: E0 goes to EXT; F0 goes to BRK, or to EXT_BRK if the current state is EXT.
  - Any other byte in IDLE or EXT is a make. In BRK or EXT_BRK it is a break. The FSM then returns to IDLE.
  - Unmapped codes have no effect.
- Make of key k:
  - If k is already held (typematic repeat), nothing changes.
  - Otherwise set key_held[k] and allocate the lowest-numbered free voice: active=1, key=k, counter=0, phase=1.
  - If no voice is free, key_held[k] is still set, no voice is allocated, and voice_overflow is set.
- Break of key k: clear key_held[k] and free the voice holding k, if any. Break of an unheld key is ignored.
- Voice: each cycle while active, counter increments. When counter reaches half-period(key)-1, counter wraps to 0 and phase toggles. Contribution is +AMPLITUDE if phase=1, -AMPLITUDE if phase=0, and 0 if inactive.
- Mixer: registered signed sum of all contributions, width SAMPLE_W. No saturation is needed, guaranteed by the elaboration check.
- Output pacing:
  - A tick fires every SAMPLE_DIV cycles.
  - On a tick, the mix is latched into the output registers and pending is set. If pending was already set, the latch still happens and sample_dropped is set.
  - While pending=1 and audio_out_allowed=1, write_audio_out pulses for one cycle and pending clears.

## Timing
- Reset, synchronous, takes priority over all other activity, including mid-sequence:
  - Parser returns to IDLE.
  - key_held, voice_active, both sticky flags, write_audio_out, pending, the tick divider and both sample outputs are cleared to 0.
- Latency:
  - A strobe at cycle t updates key_held and voice state at t+1.
  - The mix reflects the change at t+2.
  - The sample outputs change at the first tick at or after t+2.
  - write_audio_out fires in the same cycle as the tick if audio_out_allowed=1; otherwise in the first later cycle with audio_out_allowed=1.
- Make and break of different keys never occur in the same cycle, because there is one byte per strobe.
- When a voice is freed and reallocated, the new voice starts at counter=0, phase=1.
- Strobes arriving every cycle must be accepted; there is no backpressure.

## Test plan
- Reset mid-sequence: E0 is decoded, then reset, then byte 75 arrives. Key 0 becomes held through the non-E0 path. Sample outputs and all flags read 0 immediately after reset.
- Single key: bytes E0 75 are sent. key_held=0x01 and voice_active[0]=1. The voice toggles every 56818 cycles. Latched samples are ±25000000. Bytes E0 F0 75 return everything to 0.
- Polyphony: 29 then 1C are sent. voice_active=0011 and the mix takes values in {-50000000, 0, +50000000}. Break of 29 frees voice 0. Next make of 1B lands in voice 0.
- Overflow: five distinct makes with NUM_VOICES=4. The fifth key shows key_held set but gets no voice, and voice_overflow=1. Repeated 29 makes leave the voice count unchanged.
- Handshake: audio_out_allowed is held low for 3000 cycles. One write is pending, sample_dropped=1, and exactly one write_audio_out pulse appears when allowed rises.
- Unmapped and stray bytes: 0x15, an F0 15 pair, and a break of an unheld key cause no state change.
